// File: rtl/scr_arb_pkg.sv
// Shared types and default sizes for the scratch RAM arbiter slice.
//   arb_state_t : arbiter FSM state (IDLE = CPU owns the RAM port, XFER = DMA burst beat)
//   *_DEF       : default address / data / burst-length widths and starvation limit
//   cnt_width() : bit width needed to hold 0..max_val (at least 1 bit)
package scr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 10;
  localparam int LEN_W_DEF    = 4;
  localparam int MAX_WAIT_DEF = 7;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/scratch_ram_arbiter_if.sv
// Bus bundle between the EX-stage scratch port, the DMA/debug port and SCRATCH_RAM.
//   CPU side : cpu_we, cpu_re, cpu_addr, cpu_wdata -> arbiter; cpu_rdata, cpu_stall <- arbiter
//   DMA side : dma_req, dma_we, dma_addr, dma_len, dma_wdata -> arbiter;
//              dma_gnt, dma_rdata, dma_rvalid, dma_done <- arbiter
//   RAM side : ram_we, ram_addr, ram_wdata <- arbiter; ram_rdata -> arbiter
// Handshake: the DMA raises dma_req (level) with dma_we/dma_addr/dma_len stable and holds it
// until it sees its first dma_gnt; every cycle with dma_gnt=1 is one executed beat (write
// data taken from dma_wdata that same cycle), read data appears on dma_rdata with
// dma_rvalid one cycle after its beat, and dma_done pulses the cycle after the last beat.
// A CPU access seeing cpu_stall=1 was not performed and must be held for the next cycle.
// Modports: slave = arbiter view, master = surrounding system view.
interface scratch_ram_arbiter_if
  import scr_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);
  logic              cpu_we;
  logic              cpu_re;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [LEN_W-1:0]  dma_len;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic              dma_done;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_we, cpu_re, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid, dma_done,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_we, cpu_re, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid, dma_done,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of cycles a pending DMA request has lost to the CPU.
//   clk, rst : clock, synchronous active-high reset
//   inc      : DMA lost arbitration this cycle (count up, sticks at MAX_WAIT)
//   clr      : request granted or withdrawn (back to 0; wins over inc)
//   at_max   : count has reached MAX_WAIT (always 1 when MAX_WAIT = 0)
module arb_starve_counter
  import scr_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int            CW    = cnt_width(MAX_WAIT);
  localparam logic [CW-1:0] MAX_V = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wait_cnt <= '0;
    end else if (inc && (wait_cnt != MAX_V)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign at_max = (wait_cnt == MAX_V);

endmodule

// File: rtl/scratch_ram_arbiter.sv
// Shares the single-port SCRATCH_RAM between the CPU execute stage (priority) and a
// DMA/debug port. A pending DMA request is forced through after MAX_WAIT lost cycles.
// A granted DMA runs address-incrementing beats (wrapping at ADDR_W); CPU accesses during
// a beat are stalled.
//   clk, rst  : clock, synchronous active-high reset (aborts a burst at once, gates RAM writes)
//   bus       : scratch_ram_arbiter_if.slave (CPU, DMA and RAM signals)
//   dbg_state : current FSM state
// Build option: SCR_ARB_BURST_EN defined -> bursts of dma_len+1 beats;
//               undefined -> every grant is a single beat and dma_len is ignored.
module scratch_ram_arbiter
  import scr_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  scratch_ram_arbiter_if.slave  bus,
  output arb_state_t            dbg_state
);

  arb_state_t        state;
  logic [ADDR_W-1:0] cur_addr;
  logic              lat_we;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              done_q;

  logic cpu_access;
  logic in_xfer;
  logic grant;
  logic at_max;
  logic last_beat;

`ifdef SCR_ARB_BURST_EN
  logic [LEN_W-1:0] lat_len;
  logic [LEN_W-1:0] beat_cnt;
  assign last_beat = (beat_cnt == lat_len);
`else
  logic unused_len;
  assign unused_len = ^bus.dma_len;
  assign last_beat  = 1'b1;
`endif

  // A simultaneous write+read is a write, so only cpu_we reaches the RAM.
  assign cpu_access = bus.cpu_we | bus.cpu_re;
  assign in_xfer    = (state == XFER);
  assign grant      = !in_xfer && bus.dma_req && (!cpu_access || at_max);

  arb_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (!in_xfer && bus.dma_req && cpu_access && !grant),
    .clr    (in_xfer || !bus.dma_req || grant),
    .at_max (at_max)
  );

  // RAM port mux. rst gates the write strobe so a burst aborted by reset
  // writes nothing in the reset cycle itself.
  always_comb begin
    bus.ram_we    = 1'b0;
    bus.ram_addr  = bus.cpu_addr;
    bus.ram_wdata = bus.cpu_wdata;
    if (in_xfer) begin
      bus.ram_we    = lat_we && !rst;
      bus.ram_addr  = cur_addr;
      bus.ram_wdata = bus.dma_wdata;
    end else begin
      bus.ram_we    = bus.cpu_we && !rst;
    end
  end

  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.cpu_stall  = in_xfer && cpu_access && !rst;
  assign bus.dma_gnt    = in_xfer && !rst;
  assign bus.dma_rdata  = rdata_q;
  assign bus.dma_rvalid = rvalid_q;
  assign bus.dma_done   = done_q;
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_addr <= '0;
      lat_we   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef SCR_ARB_BURST_EN
      lat_len  <= '0;
      beat_cnt <= '0;
`endif
    end else begin
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state    <= XFER;
            cur_addr <= bus.dma_addr;
            lat_we   <= bus.dma_we;
`ifdef SCR_ARB_BURST_EN
            lat_len  <= bus.dma_len;
            beat_cnt <= '0;
`endif
          end
        end
        XFER: begin
          cur_addr <= cur_addr + ADDR_W'(1);
          if (!lat_we) begin
            rdata_q  <= bus.ram_rdata;
            rvalid_q <= 1'b1;
          end
`ifdef SCR_ARB_BURST_EN
          beat_cnt <= beat_cnt + LEN_W'(1);
`endif
          if (last_beat) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scratch_ram_arbiter.sv
module tb_scratch_ram_arbiter;
  import scr_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 10;
  localparam int LW = 4;
  localparam int MW = 7;
`ifdef SCR_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scratch_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();
  arb_state_t dbg_state;

  scratch_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_WAIT(MW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // SCRATCH_RAM: asynchronous read, synchronous write
  logic [DW-1:0] ram [256] = '{default: '0};
  assign bus.ram_rdata = ram[bus.ram_addr];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] exp_mem [256];
  bit            m_busy, m_wr, m_rvalid, m_done;
  int            m_addr, m_left, m_waited;
  logic [DW-1:0] m_rdata;

  // per-scenario observations
  int gnt_cnt, stall_cnt, done_cnt, first_gnt, last_gnt, done_at;
  logic [DW-1:0] rv_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reset_stats();
    gnt_cnt = 0; stall_cnt = 0; done_cnt = 0;
    first_gnt = -1; last_gnt = -1; done_at = -1;
    cyc = 0;
    rv_q.delete();
    exp_q.delete();
  endtask

  // One clock cycle: inputs are already driven; compare at negedge, step model, advance.
  task automatic cycle();
    bit acc;
    @(negedge clk);
    acc = bus.cpu_we | bus.cpu_re;
    chk("dma_gnt", bus.dma_gnt, !rst && m_busy);
    chk("cpu_stall", bus.cpu_stall, !rst && m_busy && acc);
    chk("ram_we", bus.ram_we, rst ? 1'b0 : (m_busy ? m_wr : bus.cpu_we));
    chk("dma_rvalid", bus.dma_rvalid, m_rvalid);
    chk("dma_done", bus.dma_done, m_done);
    chk("dma_rdata", bus.dma_rdata, m_rdata);
    if (!rst) chk("dbg_state", dbg_state, m_busy ? XFER : IDLE);
    if (!rst && m_busy) chk("ram_addr", bus.ram_addr, m_addr);
    if (!rst && !m_busy && bus.cpu_re && !bus.cpu_we)
      chk("cpu_rdata", bus.cpu_rdata, exp_mem[bus.cpu_addr]);

    if (bus.dma_gnt) begin
      gnt_cnt++;
      if (first_gnt < 0) first_gnt = cyc;
      last_gnt = cyc;
      if (bus.cpu_stall) stall_cnt++;
    end
    if (bus.dma_done) begin
      done_cnt++;
      done_at = cyc;
    end
    if (bus.dma_rvalid) rv_q.push_back(bus.dma_rdata);

    m_rvalid = 1'b0;
    m_done   = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_waited = 0; m_rdata = '0;
    end else if (m_busy) begin
      if (m_wr) exp_mem[m_addr] = bus.dma_wdata;
      else begin
        m_rvalid = 1'b1;
        m_rdata  = exp_mem[m_addr];
      end
      m_addr = (m_addr + 1) % 256;
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      if (bus.cpu_we) exp_mem[bus.cpu_addr] = bus.cpu_wdata;
      if (bus.dma_req && (!acc || m_waited >= MW)) begin
        m_busy   = 1'b1;
        m_wr     = bus.dma_we;
        m_addr   = int'(bus.dma_addr);
        m_left   = BURST ? int'(bus.dma_len) + 1 : 1;
        m_waited = 0;
      end else if (bus.dma_req) begin
        m_waited = (m_waited < MW) ? m_waited + 1 : MW;
      end else begin
        m_waited = 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu_idle();
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
  endtask

  task automatic cpu_write(input int addr, input int data);
    bus.cpu_we = 1'b1; bus.cpu_re = 1'b0;
    bus.cpu_addr = AW'(addr); bus.cpu_wdata = DW'(data);
    cycle();
    cpu_idle();
  endtask

  // Raise a DMA request, drop it once granted, supply wdata = wbase + beat index.
  task automatic run_dma(input bit we, input int addr, input int len, input int wbase,
                         input int n_cyc);
    int beat;
    beat = 0;
    bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = AW'(addr); bus.dma_len = LW'(len);
    for (int i = 0; i < n_cyc; i++) begin
      bus.dma_wdata = DW'(wbase + beat);
      if (m_busy) beat++;
      cycle();
      if (m_busy) bus.dma_req = 1'b0;
    end
    bus.dma_req = 1'b0;
  endtask

  // ---------------- table-driven CPU-only vectors ----------------
  typedef struct {
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            chk_rd;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    m_busy = 1'b0; m_wr = 1'b0; m_rvalid = 1'b0; m_done = 1'b0;
    m_addr = 0; m_left = 0; m_waited = 0; m_rdata = '0;
    cpu_idle();
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_len = '0;
    bus.dma_wdata = '0;
    reset_stats();

    vecs[0] = '{1'b1, 1'b0, 8'h10, 10'h155, 1'b0, 10'h000};
    vecs[1] = '{1'b0, 1'b1, 8'h10, 10'h000, 1'b1, 10'h155};
    vecs[2] = '{1'b1, 1'b0, 8'hFF, 10'h3FF, 1'b0, 10'h000};
    vecs[3] = '{1'b0, 1'b1, 8'hFF, 10'h000, 1'b1, 10'h3FF};
    vecs[4] = '{1'b1, 1'b1, 8'h11, 10'h0AA, 1'b0, 10'h000};
    vecs[5] = '{1'b0, 1'b1, 8'h11, 10'h000, 1'b1, 10'h0AA};
    vecs[6] = '{1'b0, 1'b1, 8'h10, 10'h000, 1'b1, 10'h155};
    vecs[7] = '{1'b0, 1'b1, 8'h12, 10'h000, 1'b1, 10'h000};

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dma_gnt", bus.dma_gnt, 1'b0);
    chk("rst_cpu_stall", bus.cpu_stall, 1'b0);
    chk("rst_dma_rvalid", bus.dma_rvalid, 1'b0);
    chk("rst_dma_done", bus.dma_done, 1'b0);
    chk("rst_dma_rdata", bus.dma_rdata, 10'h000);
    chk("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    @(posedge clk);
    #1;

    // 1: CPU-only traffic from the vector table
    for (int i = 0; i < 8; i++) begin
      bus.cpu_we = vecs[i].we; bus.cpu_re = vecs[i].re;
      bus.cpu_addr = vecs[i].addr; bus.cpu_wdata = vecs[i].wdata;
      @(negedge clk);
      chk("vec_cpu_stall", bus.cpu_stall, 1'b0);
      if (vecs[i].chk_rd) chk("vec_cpu_rdata", bus.cpu_rdata, vecs[i].exp_rd);
      @(posedge clk);
      #1;
      if (vecs[i].we) exp_mem[vecs[i].addr] = vecs[i].wdata;
    end
    cpu_idle();

    // 2: DMA write burst from idle, 0x20 len 3 data 1..4
    reset_stats();
    run_dma(1'b1, 8'h20, 3, 1, 10);
    chk("wr_gnt_beats", gnt_cnt, BURST ? 4 : 1);
    chk("wr_first_gnt", first_gnt, 1);
    chk("wr_done_cnt", done_cnt, 1);
    chk("wr_done_at", done_at, last_gnt + 1);
    for (int k = 0; k < 4; k++)
      chk("wr_ram", ram[8'h20 + k], (BURST || k == 0) ? k + 1 : 0);

    // 3: starvation - CPU reads every cycle, DMA read len 1 at 0x30
    reset_stats();
    bus.cpu_re = 1'b1; bus.cpu_addr = 8'h05;
    run_dma(1'b0, 8'h30, 1, 0, MW + 6);
    cpu_idle();
    chk("starve_first_gnt", first_gnt, MW + 1);
    chk("starve_gnt_beats", gnt_cnt, BURST ? 2 : 1);
    chk("starve_stall_beats", stall_cnt, gnt_cnt);
    chk("starve_done_cnt", done_cnt, 1);

    // 4: wrap-around read 0xFE len 2
    cpu_write(8'hFE, 10'h2A1);
    cpu_write(8'hFF, 10'h2B2);
    cpu_write(8'h00, 10'h2C3);
    reset_stats();
    exp_q.push_back(10'h2A1);
    if (BURST) begin
      exp_q.push_back(10'h2B2);
      exp_q.push_back(10'h2C3);
    end
    run_dma(1'b0, 8'hFE, 2, 0, 8);
    chk("wrap_rvalid_cnt", rv_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < rv_q.size(); k++)
      chk("wrap_rdata", rv_q[k], exp_q[k]);
    chk("wrap_done_at", done_at, last_gnt + 1);

    // 5: reset during beat 2 of an 8-beat write at 0x40
    reset_stats();
    begin
      int beat;
      beat = 0;
      bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h40; bus.dma_len = 4'd7;
      for (int i = 0; i < 12; i++) begin
        bus.dma_wdata = DW'(10'h100 + beat);
        rst = BURST ? (m_busy && beat == 2) : (i == 4);
        if (m_busy) beat++;
        cycle();
        rst = 1'b0;
        if (m_busy) bus.dma_req = 1'b0;
      end
      bus.dma_req = 1'b0;
    end
    chk("rst_burst_ram0", ram[8'h40], 10'h100);
    chk("rst_burst_ram1", ram[8'h41], BURST ? 10'h101 : 10'h000);
    chk("rst_burst_ram2", ram[8'h42], 10'h000);
    chk("rst_burst_gnt", gnt_cnt, BURST ? 2 : 1);
    chk("rst_burst_done", done_cnt, BURST ? 0 : 1);

    // 6: len=5 request - burst length depends on the build option
    reset_stats();
    run_dma(1'b1, 8'h60, 5, 10'h050, 10);
    chk("len5_gnt_beats", gnt_cnt, BURST ? 6 : 1);
    chk("len5_done_cnt", done_cnt, 1);
    chk("len5_done_at", done_at, last_gnt + 1);

    // randomized traffic against the reference model
    reset_stats();
    for (int i = 0; i < 800; i++) begin
      bus.cpu_we    = ($urandom_range(0, 3) == 0);
      bus.cpu_re    = ($urandom_range(0, 2) == 0);
      bus.cpu_addr  = AW'($urandom_range(0, 255));
      bus.cpu_wdata = DW'($urandom);
      bus.dma_wdata = DW'($urandom);
      if (m_busy) begin
        bus.dma_we   = $urandom_range(0, 1) == 1;
        bus.dma_addr = AW'($urandom);
        bus.dma_len  = LW'($urandom);
      end else if (!bus.dma_req && $urandom_range(0, 3) == 0) begin
        bus.dma_req  = 1'b1;
        bus.dma_we   = $urandom_range(0, 1) == 1;
        bus.dma_addr = AW'($urandom_range(0, 255));
        bus.dma_len  = LW'($urandom_range(0, 5));
      end
      cycle();
      if (m_busy) bus.dma_req = 1'b0;
    end
    cpu_idle();
    bus.dma_req = 1'b0;
    repeat (12) cycle();
    begin
      int bad;
      bad = 0;
      for (int a = 0; a < 256; a++) if (ram[a] !== exp_mem[a]) bad++;
      chk("mem_image", bad, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
